// File: rtl/control_unit_if.sv
// Decode bus between the datapath and the main decoder: instruction fields and ALU flag in,
// every datapath select and strobe out.
interface control_unit_if;
    logic [5:0] opcode;
    logic [5:0] funct;
    logic       zero;
    logic       seu_en;
    logic       alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] dw_sel;
    logic [1:0] rw_sel;
    logic       rf_wr;
    logic       dm_wr;
    logic       dm_rd;
    logic [1:0] next_pc_sel;

    modport master (
        output opcode, funct, zero,
        input  seu_en, alu_src_b, alu_op, dw_sel, rw_sel, rf_wr, dm_wr, dm_rd, next_pc_sel
    );

    modport slave (
        input  opcode, funct, zero,
        output seu_en, alu_src_b, alu_op, dw_sel, rw_sel, rf_wr, dm_wr, dm_rd, next_pc_sel
    );
endinterface

// File: rtl/control_unit.sv
// Combinational main decoder for the single-cycle MIPS subset, with a run flag that holds all
// state-changing strobes low until the first clock edge after reset.
module control_unit (
    input logic          clk,
    input logic          rst_n,
    control_unit_if.slave cu
);
    logic       run_q;
    logic       seu_en;
    logic       alu_src_b;
    logic [3:0] alu_op;
    logic [1:0] dw_sel;
    logic [1:0] rw_sel;
    logic       rf_wr;
    logic       dm_wr;
    logic       dm_rd;
    logic [1:0] next_pc_sel;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            run_q <= 1'b0;
        end else begin
            run_q <= 1'b1;
        end
    end

    always_comb begin
        seu_en      = 1'b0;
        alu_src_b   = 1'b0;
        alu_op      = 4'b0010;
        dw_sel      = 2'b00;
        rw_sel      = 2'b00;
        rf_wr       = 1'b0;
        dm_wr       = 1'b0;
        dm_rd       = 1'b0;
        next_pc_sel = 2'b00;
        unique case (cu.opcode)
            6'b000000: begin
                if (cu.funct == 6'b001000) begin
                    next_pc_sel = 2'b11;
                end else begin
                    // Only recognised ALU functs write rd; others fall back to a no-op.
                    rw_sel = 2'b01;
                    rf_wr  = 1'b1;
                    unique case (cu.funct)
                        6'b100000: alu_op = 4'b0010;
                        6'b100010: alu_op = 4'b0110;
                        6'b100100: alu_op = 4'b0000;
                        6'b100101: alu_op = 4'b0001;
                        6'b100110: alu_op = 4'b0011;
                        6'b100111: alu_op = 4'b1100;
                        6'b101010: alu_op = 4'b0111;
                        6'b000000: alu_op = 4'b1000;
                        6'b000010: alu_op = 4'b1001;
                        default: begin
                            rw_sel = 2'b00;
                            rf_wr  = 1'b0;
                        end
                    endcase
                end
            end
            6'b001000: begin seu_en = 1'b1; alu_src_b = 1'b1; rf_wr = 1'b1; end
            6'b001010: begin
                seu_en = 1'b1; alu_src_b = 1'b1; alu_op = 4'b0111; rf_wr = 1'b1;
            end
            6'b001100: begin alu_src_b = 1'b1; alu_op = 4'b0000; rf_wr = 1'b1; end
            6'b001101: begin alu_src_b = 1'b1; alu_op = 4'b0001; rf_wr = 1'b1; end
            6'b001111: begin alu_src_b = 1'b1; alu_op = 4'b1010; rf_wr = 1'b1; end
            6'b100011: begin
                seu_en = 1'b1; alu_src_b = 1'b1; dm_rd = 1'b1; dw_sel = 2'b01; rf_wr = 1'b1;
            end
            6'b101011: begin seu_en = 1'b1; alu_src_b = 1'b1; dm_wr = 1'b1; end
            6'b000100: begin
                seu_en      = 1'b1;
                alu_op      = 4'b0110;
                next_pc_sel = cu.zero ? 2'b01 : 2'b00;
            end
            6'b000101: begin
                seu_en      = 1'b1;
                alu_op      = 4'b0110;
                next_pc_sel = cu.zero ? 2'b00 : 2'b01;
            end
            6'b000010: next_pc_sel = 2'b10;
            6'b000011: begin
                next_pc_sel = 2'b10; rf_wr = 1'b1; rw_sel = 2'b10; dw_sel = 2'b10;
            end
            default: ;
        endcase
    end

    // rst_n gates directly so strobes drop in the same instant reset asserts.
    assign cu.seu_en      = seu_en;
    assign cu.alu_src_b   = alu_src_b;
    assign cu.alu_op      = alu_op;
    assign cu.dw_sel      = dw_sel;
    assign cu.rw_sel      = rw_sel;
    assign cu.rf_wr       = rf_wr & run_q & rst_n;
    assign cu.dm_wr       = dm_wr & run_q & rst_n;
    assign cu.dm_rd       = dm_rd & run_q & rst_n;
    assign cu.next_pc_sel = (run_q & rst_n) ? next_pc_sel : 2'b00;
endmodule

// File: tb/tb_control_unit.sv
// Randomised scoreboard bench for control_unit: stimulus pushes expected decodes, a monitor
// pops and compares each one shortly after the inputs settle.
module tb_control_unit;
    typedef struct packed {
        logic       seu_en;
        logic       alu_src_b;
        logic [3:0] alu_op;
        logic [1:0] dw_sel;
        logic [1:0] rw_sel;
        logic       rf_wr;
        logic       dm_wr;
        logic       dm_rd;
        logic [1:0] next_pc_sel;
    } ctl_t;

    logic clk;
    logic rst_n;
    int   n_cmp;
    int   n_err;
    int   n_push;
    bit   run_m;
    ctl_t exp_q[$];
    event chk_ev;

    control_unit_if bus ();

    control_unit dut (
        .clk  (clk),
        .rst_n(rst_n),
        .cu   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic ctl_t model(input logic [5:0] op, input logic [5:0] fn, input logic z,
                                   input bit run);
        ctl_t e;
        e = '{seu_en: 1'b0, alu_src_b: 1'b0, alu_op: 4'b0010, dw_sel: 2'b00, rw_sel: 2'b00,
              rf_wr: 1'b0, dm_wr: 1'b0, dm_rd: 1'b0, next_pc_sel: 2'b00};
        case (op)
            6'o00: begin
                case (fn)
                    6'b100000: begin e.alu_op = 4'b0010; e.rw_sel = 2'b01; e.rf_wr = 1; end
                    6'b100010: begin e.alu_op = 4'b0110; e.rw_sel = 2'b01; e.rf_wr = 1; end
                    6'b100100: begin e.alu_op = 4'b0000; e.rw_sel = 2'b01; e.rf_wr = 1; end
                    6'b100101: begin e.alu_op = 4'b0001; e.rw_sel = 2'b01; e.rf_wr = 1; end
                    6'b100110: begin e.alu_op = 4'b0011; e.rw_sel = 2'b01; e.rf_wr = 1; end
                    6'b100111: begin e.alu_op = 4'b1100; e.rw_sel = 2'b01; e.rf_wr = 1; end
                    6'b101010: begin e.alu_op = 4'b0111; e.rw_sel = 2'b01; e.rf_wr = 1; end
                    6'b000000: begin e.alu_op = 4'b1000; e.rw_sel = 2'b01; e.rf_wr = 1; end
                    6'b000010: begin e.alu_op = 4'b1001; e.rw_sel = 2'b01; e.rf_wr = 1; end
                    6'b001000: e.next_pc_sel = 2'b11;
                    default: ;
                endcase
            end
            6'b001000: begin e.seu_en = 1; e.alu_src_b = 1; e.rf_wr = 1; end
            6'b001010: begin e.seu_en = 1; e.alu_src_b = 1; e.alu_op = 4'b0111; e.rf_wr = 1; end
            6'b001100: begin e.alu_src_b = 1; e.alu_op = 4'b0000; e.rf_wr = 1; end
            6'b001101: begin e.alu_src_b = 1; e.alu_op = 4'b0001; e.rf_wr = 1; end
            6'b001111: begin e.alu_src_b = 1; e.alu_op = 4'b1010; e.rf_wr = 1; end
            6'b100011: begin
                e.seu_en = 1; e.alu_src_b = 1; e.dm_rd = 1; e.dw_sel = 2'b01; e.rf_wr = 1;
            end
            6'b101011: begin e.seu_en = 1; e.alu_src_b = 1; e.dm_wr = 1; end
            6'b000100: begin e.seu_en = 1; e.alu_op = 4'b0110; e.next_pc_sel = z ? 2 : 0; end
            6'b000101: begin e.seu_en = 1; e.alu_op = 4'b0110; e.next_pc_sel = z ? 0 : 1; end
            6'b000010: e.next_pc_sel = 2'b10;
            6'b000011: begin e.next_pc_sel = 2'b10; e.rf_wr = 1; e.rw_sel = 2; e.dw_sel = 2; end
            default: ;
        endcase
        if (op == 6'b000100 && z) e.next_pc_sel = 2'b01;
        if (!run) begin
            e.rf_wr       = 1'b0;
            e.dm_wr       = 1'b0;
            e.dm_rd       = 1'b0;
            e.next_pc_sel = 2'b00;
        end
        return e;
    endfunction

    task automatic push_expect();
        exp_q.push_back(model(bus.opcode, bus.funct, bus.zero, run_m));
        n_push++;
        ->chk_ev;
    endtask

    // One cycle: inputs change at the falling edge, run flag credited for the rising edge just past.
    task automatic step(input logic [5:0] op, input logic [5:0] fn, input logic z,
                        input logic rst);
        @(negedge clk);
        if (rst_n) run_m = 1'b1;
        rst_n      = rst;
        if (!rst) run_m = 1'b0;
        bus.opcode = op;
        bus.funct  = fn;
        bus.zero   = z;
        push_expect();
    endtask

    // Reset asserted between edges, with the instruction held.
    task automatic async_reset();
        @(negedge clk);
        if (rst_n) run_m = 1'b1;
        #3;
        rst_n = 1'b0;
        run_m = 1'b0;
        push_expect();
    endtask

    initial begin : monitor
        ctl_t exp_v;
        ctl_t act;
        forever begin
            @(chk_ev);
            #1;
            act = '{seu_en: bus.seu_en, alu_src_b: bus.alu_src_b, alu_op: bus.alu_op,
                    dw_sel: bus.dw_sel, rw_sel: bus.rw_sel, rf_wr: bus.rf_wr,
                    dm_wr: bus.dm_wr, dm_rd: bus.dm_rd, next_pc_sel: bus.next_pc_sel};
            n_cmp++;
            if (exp_q.size() == 0) begin
                n_err++;
                $display("FAIL scoreboard_empty t=%0t got=%h required=entry", $time, act);
            end else begin
                exp_v = exp_q.pop_front();
                if (act !== exp_v) begin
                    n_err++;
                    $display("FAIL decode op=%b fn=%b z=%b rst_n=%b t=%0t got=%h required=%h",
                             bus.opcode, bus.funct, bus.zero, rst_n, $time, act, exp_v);
                end
            end
        end
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL timeout got=running required=finished");
        $fatal(1, "timeout");
    end

    initial begin : stimulus
        logic [5:0] ops[14];
        logic [5:0] fns[10];
        logic [5:0] op;
        logic [5:0] fn;
        ops = '{6'o00, 6'o00, 6'b001000, 6'b001010, 6'b001100, 6'b001101, 6'b001111,
                6'b100011, 6'b101011, 6'b000100, 6'b000101, 6'b000010, 6'b000011, 6'o00};
        fns = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b100110, 6'b100111,
                6'b101010, 6'b000000, 6'b000010, 6'b001000};
        n_cmp = 0; n_err = 0; n_push = 0; run_m = 1'b0;
        rst_n = 1'b0;
        bus.opcode = 6'b100011; bus.funct = 6'b0; bus.zero = 1'b0;

        // Reset held with lw, then released and clocked.
        step(6'b100011, 6'b0, 1'b0, 1'b0);
        step(6'b100011, 6'b0, 1'b0, 1'b1);
        step(6'b100011, 6'b0, 1'b0, 1'b1);
        step(6'b000000, 6'b100000, 1'b0, 1'b1);
        step(6'b000000, 6'b100000, 1'b1, 1'b1);
        step(6'b000011, 6'b0, 1'b0, 1'b1);
        step(6'b000100, 6'b0, 1'b1, 1'b1);
        step(6'b000100, 6'b0, 1'b0, 1'b1);
        step(6'b000101, 6'b0, 1'b0, 1'b1);
        step(6'b000101, 6'b0, 1'b1, 1'b1);
        step(6'b101011, 6'b0, 1'b0, 1'b1);
        step(6'b001101, 6'b0, 1'b0, 1'b1);
        step(6'b000000, 6'b001000, 1'b0, 1'b1);
        step(6'b111111, 6'b0, 1'b1, 1'b1);
        step(6'b000000, 6'b111111, 1'b0, 1'b1);

        // Mid-instruction reset on a branch, then recovery.
        step(6'b000101, 6'b0, 1'b0, 1'b1);
        async_reset();
        step(6'b100011, 6'b0, 1'b0, 1'b0);
        step(6'b101011, 6'b0, 1'b0, 1'b1);
        step(6'b101011, 6'b0, 1'b0, 1'b1);

        for (int i = 0; i < 400; i++) begin
            op = ($urandom_range(3) != 0) ? ops[$urandom_range(13)] : 6'($urandom);
            fn = ($urandom_range(3) != 0) ? fns[$urandom_range(9)] : 6'($urandom);
            if ($urandom_range(59) == 0) begin
                async_reset();
            end else begin
                step(op, fn, 1'($urandom), (rst_n || $urandom_range(1) == 0));
            end
        end

        #20;
        if (exp_q.size() != 0 || n_cmp != n_push) begin
            n_err++;
            $display("FAIL scoreboard_drain got=%0d compared required=%0d pushed", n_cmp, n_push);
        end
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule

// File: doc/control_unit.md
# control_unit

Combinational main decoder for the single-cycle MIPS-subset processor. It maps the instruction's opcode and funct fields, plus the ALU zero flag, to every datapath select and enable: extender mode, ALU operand and operation, register-file write address and data source, data-memory strobes, and next-PC source. A one-bit run flag, clocked and asynchronously reset, suppresses all state-changing strobes until the first clock edge after reset.

## Interface
- No parameters.
- clk  in  1  system clock; only the run flag is clocked.
- rst_n  in  1  asynchronous active-low reset; one clock, reset is asynchronous and active-low.
- opcode  in  6  instruction bits [31:26].
- funct  in  6  instruction bits [5:0]; decoded only when opcode = 000000.
- zero  in  1  ALU result-equals-zero flag, used for branches.
- seu_en  out  1  immediate extension: 1 = sign-extend, 0 = zero-extend.
- alu_src_b  out  1  ALU B operand: 0 = register rt, 1 = extended immediate.
- alu_op  out  4  AND 0000, OR 0001, ADD 0010, XOR 0011, SUB 0110, SLT 0111, SLL 1000, SRL 1001, LUI 1010, NOR 1100.
- dw_sel  out  2  register write-data source: 00 = ALU, 01 = data memory, 10 = PC+4, 11 = reserved (treated as ALU).
- rw_sel  out  2  write register: 00 = rt, 01 = rd, 10 = $31, 11 = reserved.
- rf_wr  out  1  register-file write enable.
- dm_wr  out  1  data-memory write enable.
- dm_rd  out  1  data-memory read enable.
- next_pc_sel  out  2  next-PC source: 00 = PC+4, 01 = branch target, 10 = jump target, 11 = register rs (jr).

## Operation
Default values for fields not listed in a row below: seu_en=0, alu_src_b=0, alu_op=0010, dw_sel=00, rw_sel=00, rf_wr=0, dm_wr=0, dm_rd=0, next_pc_sel=00.

**R-type (opcode 000000).** All rows use rw_sel=01 and rf_wr=1.

| funct | Instruction | alu_op |
|---|---|---|
| 100000 | add | 0010 |
| 100010 | sub | 0110 |
| 100100 | and | 0000 |
| 100101 | or | 0001 |
| 100110 | xor | 0011 |
| 100111 | nor | 1100 |
| 101010 | slt | 0111 |
| 000000 | sll | 1000 |
| 000010 | srl | 1001 |

- funct 001000 (jr): rf_wr=0, next_pc_sel=11.
- Any other funct: defaults, so no write.

**I-type.** All rows use alu_src_b=1 and rw_sel=00.

| opcode | Instruction | Fields |
|---|---|---|
| 001000 | addi | seu_en=1, alu_op=0010, rf_wr=1 |
| 001010 | slti | seu_en=1, alu_op=0111, rf_wr=1 |
| 001100 | andi | seu_en=0, alu_op=0000, rf_wr=1 |
| 001101 | ori | seu_en=0, alu_op=0001, rf_wr=1 |
| 001111 | lui | alu_op=1010, rf_wr=1 |
| 100011 | lw | seu_en=1, alu_op=0010, dm_rd=1, dw_sel=01, rf_wr=1 |
| 101011 | sw | seu_en=1, alu_op=0010, dm_wr=1, rf_wr=0 |

**Branches.** seu_en=1, alu_src_b=0, alu_op=0110, no writes.
- 000100 beq: next_pc_sel = 01 if zero=1, else 00.
- 000101 bne: next_pc_sel = 01 if zero=0, else 00.

**Jumps.**
- 000010 j: next_pc_sel=10, no writes.
- 000011 jal: next_pc_sel=10, rf_wr=1, rw_sel=10, dw_sel=10.

**Unrecognised opcode.** Defaults (no-op that advances the PC).

**Run flag.**
- Cleared asynchronously by rst_n=0.
- Set on the first rising clk edge with rst_n=1.
- Stays set until the next reset.
- While the flag is 0, rf_wr, dm_wr and dm_rd are forced to 0 and next_pc_sel is forced to 00.
- Other outputs still follow the decode.

## Timing
- Decode path is purely combinational, with zero cycles of latency.
- Outputs settle in the same cycle whenever opcode, funct or zero changes, including when zero toggles in the middle of an instruction.
- No inferred latches: every output is assigned on every path.
- Reset asserted:
  - Strobes and next_pc_sel go to 0 immediately, without waiting for clk.
  - They remain 0 through the first post-release edge.
  - Normal gating starts after that edge.
- Reset asserted mid-instruction: strobes drop to 0 asynchronously in the same instant.

## Test plan
1. rst_n=0, opcode=100011 → rf_wr=0, dm_rd=0, dm_wr=0, next_pc_sel=00, alu_op=0010. Release reset and clock once → dm_rd=1, rf_wr=1, dw_sel=01, alu_src_b=1.
2. opcode=000000, funct=100000, zero toggling 0/1 → rf_wr=1, rw_sel=01, alu_src_b=0, alu_op=0010, dw_sel=00, next_pc_sel=00, unchanged by zero.
3. opcode=000011 (jal) → next_pc_sel=10, rf_wr=1, rw_sel=10, dw_sel=10, dm_wr=0.
4. opcode=000100 with zero=1 → next_pc_sel=01. Then zero=0 → 00. Repeat with opcode=000101: zero=0 → 01, zero=1 → 00. Throughout: rf_wr=0, alu_op=0110.
5. opcode=101011 (sw) → dm_wr=1, rf_wr=0, seu_en=1, alu_src_b=1. Then opcode=001101 (ori) → seu_en=0, alu_op=0001, rf_wr=1.
6. opcode=000000, funct=001000 (jr) → next_pc_sel=11, rf_wr=0. Then opcode=111111 → all defaults, strobes 0.
